// File: rtl/subtree_resp_merger_pkg.sv
// Shared types and defaults for the subtree response fan-in path.
package subtree_pkg;

  localparam int unsigned NUM_CHILD_DEF = 5;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned SRC_W_DEF     = $clog2(NUM_CHILD_DEF);
  localparam int unsigned BEAT_CNT_W    = 16;

  // One upstream beat: payload plus index of the child that produced it.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [SRC_W_DEF-1:0]  src;
  } resp_beat_t;

  // Round-robin successor of idx among n children.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/subtree_resp_merger_if.sv
// Child-to-parent response bundle: per-child valid/ready/data in, one tagged beat out.
interface subtree_resp_merger_if
  import subtree_pkg::*;
#(
  parameter int unsigned NUM_CHILD = NUM_CHILD_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) ();

  localparam int unsigned SRC_W = $clog2(NUM_CHILD);

  logic [NUM_CHILD-1:0]        in_valid;
  logic [NUM_CHILD*DATA_W-1:0] in_data;
  logic [NUM_CHILD-1:0]        in_ready;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [SRC_W-1:0]            out_src;
  logic                        out_ready;
  logic [BEAT_CNT_W-1:0]       beat_count;

  // Environment side: children plus the upstream consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, beat_count
  );

  // Merger side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, beat_count
  );

endinterface

// File: rtl/subtree_resp_merger_rr_arbiter.sv
// Rotating-priority arbiter: search starts at ptr and wraps at NUM_CHILD-1.
module rr_arbiter
  import subtree_pkg::*;
#(
  parameter int unsigned NUM_CHILD = NUM_CHILD_DEF
) (
  input  logic [NUM_CHILD-1:0]         req,
  input  logic [$clog2(NUM_CHILD)-1:0] ptr,
  input  logic                         enable,
  output logic [NUM_CHILD-1:0]         gnt,
  output logic [$clog2(NUM_CHILD)-1:0] gnt_idx,
  output logic                         any_gnt
);

  localparam int unsigned SRC_W = $clog2(NUM_CHILD);

  logic [SRC_W:0] cand;

  // First requester at or after ptr wins; the extra cand bit absorbs ptr+k before the wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    if (enable) begin
      for (int unsigned k = 0; k < NUM_CHILD; k++) begin
        cand = {1'b0, ptr} + (SRC_W+1)'(k);
        if (cand >= (SRC_W+1)'(NUM_CHILD)) begin
          cand = cand - (SRC_W+1)'(NUM_CHILD);
        end
        if (!any_gnt && req[cand[SRC_W-1:0]]) begin
          any_gnt                 = 1'b1;
          gnt[cand[SRC_W-1:0]]    = 1'b1;
          gnt_idx                 = cand[SRC_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/subtree_resp_merger.sv
// Fan-in merger: round-robin over child response channels into one registered, tagged upstream beat.
module subtree_resp_merger
  import subtree_pkg::*;
#(
  parameter int unsigned NUM_CHILD = NUM_CHILD_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  subtree_resp_merger_if.slave bus
);

  localparam int unsigned SRC_W = $clog2(NUM_CHILD);

  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [SRC_W-1:0]      out_src_q;
  logic [SRC_W-1:0]      ptr;
  logic [BEAT_CNT_W-1:0] beat_count_q;

  logic                  load;
  logic                  arb_en;
  logic [NUM_CHILD-1:0]  gnt;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  any_gnt;
  logic [DATA_W-1:0]     sel_data;

  // Output stage can take a new beat when empty or draining this cycle.
  // Grants are suppressed during reset so no child is handshaked into a register being cleared.
  assign load   = !out_valid_q || bus.out_ready;
  assign arb_en = load && !rst;

  rr_arbiter #(
    .NUM_CHILD (NUM_CHILD)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CHILD; i++) begin
      if (gnt[i]) begin
        sel_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register, round-robin pointer and delivered-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      ptr          <= '0;
      beat_count_q <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        beat_count_q <= beat_count_q + BEAT_CNT_W'(1);
      end
      if (load) begin
        if (any_gnt) begin
          out_valid_q <= 1'b1;
          out_data_q  <= sel_data;
          out_src_q   <= gnt_idx;
          ptr         <= SRC_W'(rr_next(32'(gnt_idx), NUM_CHILD));
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready   = gnt;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src    = out_src_q;
  assign bus.beat_count = beat_count_q;

endmodule

// File: tb/tb_subtree_resp_merger.sv
// Scoreboard bench for subtree_resp_merger: child queues feed the DUT, expected beats are checked in order.
module tb_subtree_resp_merger;
  import subtree_pkg::*;

  localparam int unsigned NC = NUM_CHILD_DEF;
  localparam int unsigned DW = DATA_W_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  subtree_resp_merger_if #(.NUM_CHILD(NC), .DATA_W(DW)) bus ();

  subtree_resp_merger #(
    .NUM_CHILD (NC),
    .DATA_W    (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned tests_run = 0;
  int unsigned failed    = 0;

  resp_beat_t    exp_q [$];
  logic [DW-1:0] child_q [NC][$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Child beat that must reach the upstream side.
  task automatic push_beat(input int unsigned c, input logic [DW-1:0] d);
    resp_beat_t b;
    b.data = d;
    b.src  = SRC_W_DEF'(c);
    child_q[c].push_back(d);
    exp_q.push_back(b);
  endtask

  task automatic flush_all();
    exp_q.delete();
    for (int unsigned i = 0; i < NC; i++) child_q[i].delete();
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_drain: %0d beats still outstanding, required 0", name, exp_q.size());
      flush_all();
    end
    tick();
    tick();
  endtask

  // Child driver: present queue heads, retire a head once its handshake is seen.
  initial begin
    logic [NC-1:0]    acc;
    logic [NC-1:0]    v;
    logic [NC*DW-1:0] d;
    bus.in_valid = '0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #2;
      v = '0;
      d = '0;
      for (int unsigned i = 0; i < NC; i++) begin
        if (acc[i] && child_q[i].size() != 0) void'(child_q[i].pop_front());
        if (child_q[i].size() != 0) begin
          v[i]            = 1'b1;
          d[i*DW +: DW]   = child_q[i][0];
        end
      end
      bus.in_valid = v;
      bus.in_data  = d;
    end
  end

  // Upstream monitor: in-order beat check and grant legality every cycle.
  initial begin
    resp_beat_t e;
    forever begin
      @(negedge clk);
      tests_run++;
      if (($countones(bus.in_ready) > 1) || ((bus.in_ready & ~bus.in_valid) != '0)) begin
        failed++;
        $display("FAIL grant_legal: in_ready=%b in_valid=%b, required at most one bit and only on a valid child",
                 bus.in_ready, bus.in_valid);
      end
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_beat: got data=%h src=%0d, required no beat", bus.out_data, bus.out_src);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.data || bus.out_src !== e.src) begin
            failed++;
            $display("FAIL beat: got data=%h src=%0d, required data=%h src=%0d",
                     bus.out_data, bus.out_src, e.data, e.src);
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < NC; i++) push_beat(i, 16'hC000 + 16'(i));
    tick();
    repeat (3) begin
      @(negedge clk);
      tests_run += 3;
      if (bus.in_ready !== 5'b00000) begin
        failed++;
        $display("FAIL reset_in_ready: got %b, required 00000", bus.in_ready);
      end
      if (bus.out_valid !== 1'b0) begin
        failed++;
        $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
      end
      if (bus.beat_count !== 16'h0000) begin
        failed++;
        $display("FAIL reset_beat_count: got %h, required 0000", bus.beat_count);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 5'b00001) begin
      failed++;
      $display("FAIL reset_first_grant: got %b, required 00001", bus.in_ready);
    end
    wait_drain("reset");
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned i = 0; i < NC; i++)
        push_beat(i, 16'hA000 + 16'(16 * r + i));
    tick();
    rst = 1'b0;
    repeat (11) tick();
    tests_run += 2;
    if (bus.beat_count !== 16'd10) begin
      failed++;
      $display("FAIL fair_beat_count: got %0d, required 10", bus.beat_count);
    end
    if (bus.out_valid !== 1'b0) begin
      failed++;
      $display("FAIL fair_idle_after: got out_valid=%b, required 0", bus.out_valid);
    end
    wait_drain("fairness");
  endtask

  task automatic test_skip_idle();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      push_beat(1, 16'hB100 + 16'(k));
      push_beat(3, 16'hB300 + 16'(k));
    end
    tick();
    rst = 1'b0;
    repeat (7) tick();
    tests_run++;
    if (bus.beat_count !== 16'd6) begin
      failed++;
      $display("FAIL skip_beat_count: got %0d, required 6", bus.beat_count);
    end
    wait_drain("skip_idle");
  endtask

  task automatic test_backpressure();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    push_beat(2, 16'h1234);
    tick();
    rst = 1'b0;
    tick();
    push_beat(3, 16'h3C3C);
    push_beat(0, 16'h00C0);
    repeat (4) begin
      @(negedge clk);
      tests_run += 4;
      if (bus.out_valid !== 1'b1) begin
        failed++;
        $display("FAIL bp_valid: got %b, required 1", bus.out_valid);
      end
      if (bus.out_data !== 16'h1234) begin
        failed++;
        $display("FAIL bp_data: got %h, required 1234", bus.out_data);
      end
      if (bus.out_src !== 3'd2) begin
        failed++;
        $display("FAIL bp_src: got %0d, required 2", bus.out_src);
      end
      if (bus.in_ready !== 5'b00000) begin
        failed++;
        $display("FAIL bp_in_ready: got %b, required 00000", bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 5'b01000) begin
      failed++;
      $display("FAIL bp_release_grant: got %b, required 01000", bus.in_ready);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_wrap();
    logic [15:0] want [4];
    want[0] = 16'hFFFE;
    want[1] = 16'hFFFF;
    want[2] = 16'h0000;
    want[3] = 16'h0001;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int unsigned k = 0; k < 32'd65537; k++) push_beat(k % NC, 16'(k));
    tick();
    rst = 1'b0;
    repeat (65535) tick();
    for (int unsigned j = 0; j < 4; j++) begin
      if (j != 0) tick();
      tests_run++;
      if (bus.beat_count !== want[j]) begin
        failed++;
        $display("FAIL wrap_count_%0d: got %h, required %h", j, bus.beat_count, want[j]);
      end
    end
    wait_drain("wrap");
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    child_q[4].push_back(16'h4444);  // consumed by the output register, then lost to reset
    tick();
    rst = 1'b0;
    tick();
    push_beat(1, 16'h1111);
    rst = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (bus.out_valid !== 1'b1) begin
      failed++;
      $display("FAIL mid_hold_valid: got %b, required 1", bus.out_valid);
    end
    if (bus.out_src !== 3'd4) begin
      failed++;
      $display("FAIL mid_hold_src: got %0d, required 4", bus.out_src);
    end
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (bus.out_valid !== 1'b0) begin
      failed++;
      $display("FAIL mid_discard: got out_valid=%b, required 0", bus.out_valid);
    end
    if (bus.in_ready !== 5'b00010) begin
      failed++;
      $display("FAIL mid_regrant: got %b, required 00010", bus.in_ready);
    end
    wait_drain("mid_reset");
    repeat (5) tick();
    tests_run++;
    if (bus.beat_count !== 16'd1) begin
      failed++;
      $display("FAIL mid_beat_count: got %0d, required 1", bus.beat_count);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_fairness();
    test_skip_idle();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL final_scoreboard: %0d beats outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
